// File: rtl/pattern_sequencer.sv
// rtl/pattern_sequencer.sv - memory-game flow controller: grows a random move pattern, replays it on one-hot LEDs, checks player presses
module pattern_sequencer #(
    parameter int MAX_LEN       = 8,
    parameter int ON_TICKS      = 4,
    parameter int OFF_TICKS     = 2,
    parameter int TIMEOUT_TICKS = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic [1:0] rand_in,
    input  logic       start,
    input  logic       btn_valid,
    input  logic [1:0] btn_code,
    output logic [2:0] led_out,
    output logic       wait_input,
    output logic       win,
    output logic       lose,
    output logic [3:0] level
);

    localparam int CNT_MAX_A = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
    localparam int CNT_MAX   = (CNT_MAX_A > TIMEOUT_TICKS) ? CNT_MAX_A : TIMEOUT_TICKS;
    localparam int CNT_W     = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(ON_TICKS - 1);
    localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'(OFF_TICKS - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_TICKS - 1);
    localparam logic [3:0]       LEN_MAX  = 4'(MAX_LEN);

    typedef enum logic [2:0] {
        S_IDLE,
        S_APPEND,
        S_SHOW_ON,
        S_SHOW_OFF,
        S_INPUT,
        S_WIN,
        S_LOSE
    } state_t;

    state_t           r_state;
    logic [3:0]       r_len;
    logic [3:0]       r_idx;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_led;
    logic             r_wait;
    logic             r_win;
    logic             r_lose;

    // Sized to the full 4-bit index space so every index select is width-exact.
    logic [1:0]       r_mem [16];

    state_t           w_state_nx;
    logic [3:0]       w_len_nx;
    logic [3:0]       w_idx_nx;
    logic [CNT_W-1:0] w_cnt_nx;
    logic             w_mem_we;
    logic [1:0]       w_move;
    logic [1:0]       w_expect;
    logic             w_idx_last;
    logic [1:0]       w_show_move;
    logic [2:0]       w_led_nx;

    function automatic logic [2:0] onehot(input logic [1:0] move);
        case (move)
            2'd0:    onehot = 3'b001;
            2'd1:    onehot = 3'b010;
            2'd2:    onehot = 3'b100;
            default: onehot = 3'b000;
        endcase
    endfunction

    assign w_move     = (rand_in == 2'd3) ? 2'd0 : rand_in;
    assign w_expect   = r_mem[r_idx];
    assign w_idx_last = (r_idx == (r_len - 4'd1));

    always_comb begin
        w_state_nx = r_state;
        w_len_nx   = r_len;
        w_idx_nx   = r_idx;
        w_cnt_nx   = r_cnt;
        w_mem_we   = 1'b0;

        case (r_state)
            S_IDLE, S_WIN, S_LOSE: begin
                if (start) begin
                    w_state_nx = S_APPEND;
                    w_len_nx   = 4'd0;
                end
            end
            S_APPEND: begin
                w_mem_we   = 1'b1;
                w_len_nx   = r_len + 4'd1;
                w_idx_nx   = 4'd0;
                w_cnt_nx   = '0;
                w_state_nx = S_SHOW_ON;
            end
            S_SHOW_ON: begin
                if (tick) begin
                    if (r_cnt == ON_LAST) begin
                        w_state_nx = S_SHOW_OFF;
                        w_cnt_nx   = '0;
                    end else begin
                        w_cnt_nx = r_cnt + 1'b1;
                    end
                end
            end
            S_SHOW_OFF: begin
                if (tick) begin
                    if (r_cnt == OFF_LAST) begin
                        w_cnt_nx = '0;
                        if (w_idx_last) begin
                            w_state_nx = S_INPUT;
                            w_idx_nx   = 4'd0;
                        end else begin
                            w_state_nx = S_SHOW_ON;
                            w_idx_nx   = r_idx + 4'd1;
                        end
                    end else begin
                        w_cnt_nx = r_cnt + 1'b1;
                    end
                end
            end
            S_INPUT: begin
                // A press wins over a simultaneous tick, so a timeout never fires on a press cycle.
                if (btn_valid) begin
                    if (btn_code == w_expect) begin
                        if (w_idx_last) begin
                            w_state_nx = (r_len == LEN_MAX) ? S_WIN : S_APPEND;
                        end else begin
                            w_idx_nx = r_idx + 4'd1;
                            w_cnt_nx = '0;
                        end
                    end else begin
                        w_state_nx = S_LOSE;
                    end
                end else if (tick) begin
                    if (r_cnt == TO_LAST) begin
                        w_state_nx = S_LOSE;
                    end else begin
                        w_cnt_nx = r_cnt + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase

        // The first replayed move may be the one being written this very cycle.
        w_show_move = (w_mem_we && (w_idx_nx == r_len)) ? w_move : r_mem[w_idx_nx];
        w_led_nx    = (w_state_nx == S_SHOW_ON) ? onehot(w_show_move) : 3'b000;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_len   <= 4'd0;
            r_idx   <= 4'd0;
            r_cnt   <= '0;
            r_led   <= 3'b000;
            r_wait  <= 1'b0;
            r_win   <= 1'b0;
            r_lose  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_len   <= w_len_nx;
            r_idx   <= w_idx_nx;
            r_cnt   <= w_cnt_nx;
            r_led   <= w_led_nx;
            r_wait  <= (w_state_nx == S_INPUT);
            r_win   <= (w_state_nx == S_WIN);
            r_lose  <= (w_state_nx == S_LOSE);
        end
    end

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[r_len] <= w_move;
        end
    end

    assign led_out    = r_led;
    assign wait_input = r_wait;
    assign win        = r_win;
    assign lose       = r_lose;
    assign level      = r_len;

endmodule

// File: tb/tb_pattern_sequencer.sv
// tb/tb_pattern_sequencer.sv - self-checking bench for pattern_sequencer against a pattern-queue reference model
module tb_pattern_sequencer;

    localparam int MAX_LEN = 3;
    localparam int ON      = 2;
    localparam int OFF     = 1;
    localparam int TO      = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick;
    logic [1:0] rand_in;
    logic       start;
    logic       btn_valid;
    logic [1:0] btn_code;
    logic [2:0] led_out;
    logic       wait_input;
    logic       win;
    logic       lose;
    logic [3:0] level;

    int         n_vec = 0;
    int         n_err = 0;
    int         cyc = 0;
    bit         every2 = 1'b0;
    int         rand_force = -1;
    int         pat[$];
    logic [2:0] obs[$];
    logic [2:0] expw[$];
    bit         cap_to;
    logic [3:0] lvl_seen;

    always #5 clk = ~clk;

    pattern_sequencer #(
        .MAX_LEN(MAX_LEN),
        .ON_TICKS(ON),
        .OFF_TICKS(OFF),
        .TIMEOUT_TICKS(TO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .tick(tick),
        .rand_in(rand_in),
        .start(start),
        .btn_valid(btn_valid),
        .btn_code(btn_code),
        .led_out(led_out),
        .wait_input(wait_input),
        .win(win),
        .lose(lose),
        .level(level)
    );

    // One clock; outputs are read and pulse inputs re-driven 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        start     = 1'b0;
        btn_valid = 1'b0;
        btn_code  = 2'($urandom_range(0, 3));
        tick      = every2 ? (cyc % 2 == 0) : 1'b1;
        rand_in   = (rand_force >= 0) ? 2'(rand_force) : 2'($urandom_range(0, 3));
    endtask

    function automatic logic [2:0] oh(int m);
        return 3'b001 << m;
    endfunction

    // Called in the APPEND cycle: extends the model and records the replay until INPUT.
    task automatic begin_round();
        pat.push_back((rand_in == 2'd3) ? 0 : int'(rand_in));
        obs.delete();
        cap_to = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                btn_valid = 1'b1;
                btn_code  = 2'($urandom_range(0, 3));
            end
            step();
            if (i == 0) lvl_seen = level;
            if (wait_input) begin
                cap_to = 1'b0;
                break;
            end
            obs.push_back(led_out);
        end
        expw.delete();
        foreach (pat[k]) begin
            repeat (ON) expw.push_back(oh(pat[k]));
            repeat (OFF) expw.push_back(3'b000);
        end
    endtask

    function automatic int first_diff();
        if (cap_to) return 0;
        foreach (expw[k]) begin
            if (k >= obs.size()) return k;
            if (obs[k] !== expw[k]) return k;
        end
        if (obs.size() != expw.size()) return expw.size();
        return -1;
    endfunction

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; btn_valid = 1'b0; btn_code = 2'd0; tick = 1'b1; rand_in = 2'd0;
        step();
        step();
        reset = 1'b1;
        step();
        n_vec++; if (led_out !== 3'b000) begin n_err++; $display("FAIL reset_led got=%b want=000", led_out); end
        n_vec++; if (wait_input !== 1'b0) begin n_err++; $display("FAIL reset_wait got=%b want=0", wait_input); end
        n_vec++; if (win !== 1'b0) begin n_err++; $display("FAIL reset_win got=%b want=0", win); end
        n_vec++; if (lose !== 1'b0) begin n_err++; $display("FAIL reset_lose got=%b want=0", lose); end
        n_vec++; if (level !== 4'd0) begin n_err++; $display("FAIL reset_level got=%0d want=0", level); end
        for (int i = 0; i < 4; i++) begin
            btn_valid = 1'b1;
            btn_code  = 2'($urandom_range(0, 3));
            step();
            n_vec++;
            if ({led_out, wait_input, win, lose, level} !== 10'd0) begin
                n_err++;
                $display("FAIL idle_ignores_btn got=%b want=0", {led_out, wait_input, win, lose, level});
            end
        end
    endtask

    task automatic test_first_round();
        pat.delete();
        rand_force = 2;
        start = 1'b1;
        step();
        n_vec++; if (level !== 4'd0 || led_out !== 3'b000) begin n_err++; $display("FAIL append_cycle level=%0d led=%b want 0/000", level, led_out); end
        begin_round();
        rand_force = -1;
        n_vec++; if (cap_to) begin n_err++; $display("FAIL first_replay_timeout got=stuck want=input"); end
        n_vec++; if (lvl_seen !== 4'd1) begin n_err++; $display("FAIL first_level got=%0d want=1", lvl_seen); end
        n_vec++; if (first_diff() != -1) begin n_err++; $display("FAIL first_wave at=%0d got_len=%0d want_len=%0d", first_diff(), obs.size(), expw.size()); end
        n_vec++; if (wait_input !== 1'b1) begin n_err++; $display("FAIL first_wait got=%b want=1", wait_input); end
    endtask

    task automatic test_growth();
        for (int r = 0; r < 2; r++) begin
            rand_force = (r == 0) ? 0 : 1;
            foreach (pat[k]) begin
                btn_valid = 1'b1;
                btn_code  = 2'(pat[k]);
                step();
                if (k < pat.size() - 1) begin
                    n_vec++; if (wait_input !== 1'b1) begin n_err++; $display("FAIL growth_mid_press got=%b want=1", wait_input); end
                end
            end
            n_vec++; if (level !== 4'(pat.size()) || wait_input !== 1'b0) begin n_err++; $display("FAIL growth_append level=%0d wait=%b want %0d/0", level, wait_input, pat.size()); end
            begin_round();
            n_vec++; if (lvl_seen !== 4'(pat.size())) begin n_err++; $display("FAIL growth_level got=%0d want=%0d", lvl_seen, pat.size()); end
            n_vec++; if (first_diff() != -1) begin n_err++; $display("FAIL growth_wave round=%0d at=%0d got_len=%0d want_len=%0d", r, first_diff(), obs.size(), expw.size()); end
        end
        rand_force = -1;
    endtask

    task automatic test_win_restart();
        int m;
        foreach (pat[k]) begin
            btn_valid = 1'b1;
            btn_code  = 2'(pat[k]);
            step();
        end
        n_vec++; if (win !== 1'b1 || lose !== 1'b0 || wait_input !== 1'b0) begin n_err++; $display("FAIL win_enter win=%b lose=%b wait=%b want 1/0/0", win, lose, wait_input); end
        n_vec++; if (level !== 4'(MAX_LEN)) begin n_err++; $display("FAIL win_level got=%0d want=%0d", level, MAX_LEN); end
        btn_valid = 1'b1;
        step(); step(); step();
        n_vec++; if (win !== 1'b1 || level !== 4'(MAX_LEN)) begin n_err++; $display("FAIL win_hold win=%b level=%0d want 1/%0d", win, level, MAX_LEN); end
        start = 1'b1;
        step();
        n_vec++; if (win !== 1'b0 || level !== 4'd0) begin n_err++; $display("FAIL restart_append win=%b level=%0d want 0/0", win, level); end
        m = (rand_in == 2'd3) ? 0 : int'(rand_in);
        step();
        n_vec++; if (level !== 4'd1 || led_out !== oh(m)) begin n_err++; $display("FAIL restart_show level=%0d led=%b want 1/%b", level, led_out, oh(m)); end
        reset = 1'b0;
        step();
        n_vec++; if (led_out !== 3'b000 || level !== 4'd0) begin n_err++; $display("FAIL mid_show_reset led=%b level=%0d want 000/0", led_out, level); end
        reset = 1'b1;
        step();
        step();
        n_vec++; if ({led_out, wait_input, win, lose, level} !== 10'd0) begin n_err++; $display("FAIL post_reset_idle got=%b want=0", {led_out, wait_input, win, lose, level}); end
    endtask

    task automatic test_wrong_press();
        int c;
        pat.delete();
        start = 1'b1;
        step();
        begin_round();
        n_vec++; if (first_diff() != -1) begin n_err++; $display("FAIL wrong_wave at=%0d", first_diff()); end
        start = 1'b1;
        step();
        n_vec++; if (wait_input !== 1'b1 || level !== 4'd1) begin n_err++; $display("FAIL start_ignored_input wait=%b level=%0d want 1/1", wait_input, level); end
        c = (pat[0] + 1 + int'($urandom_range(0, 1))) % 3;
        btn_valid = 1'b1;
        btn_code  = 2'(c);
        step();
        n_vec++; if (lose !== 1'b1 || wait_input !== 1'b0 || level !== 4'd1) begin n_err++; $display("FAIL wrong_code lose=%b wait=%b level=%0d want 1/0/1", lose, wait_input, level); end
        pat.delete();
        start = 1'b1;
        step();
        begin_round();
        btn_valid = 1'b1;
        btn_code  = 2'd3;
        step();
        n_vec++; if (lose !== 1'b1 || wait_input !== 1'b0) begin n_err++; $display("FAIL code3_press lose=%b wait=%b want 1/0", lose, wait_input); end
    endtask

    task automatic test_timeout();
        int  ticks;
        bit  t;
        // Part 1: silent player loses on the TO-th tick.
        every2 = 1'b0;
        pat.delete();
        start = 1'b1;
        step();
        begin_round();
        every2 = 1'b1;
        ticks = 0;
        for (int i = 0; i < 40 && ticks < TO; i++) begin
            t = tick;
            step();
            if (t) ticks++;
            n_vec++; if (lose !== (ticks >= TO)) begin n_err++; $display("FAIL timeout_basic ticks=%0d lose=%b want=%b", ticks, lose, ticks >= TO); end
        end
        n_vec++; if (ticks != TO) begin n_err++; $display("FAIL timeout_bound got=%0d want=%0d", ticks, TO); end
        // Part 2: a correct press on the would-be timeout tick restarts the window.
        every2 = 1'b0;
        pat.delete();
        start = 1'b1;
        step();
        begin_round();
        btn_valid = 1'b1;
        btn_code  = 2'(pat[0]);
        step();
        begin_round();
        every2 = 1'b1;
        ticks = 0;
        for (int i = 0; i < 40 && ticks < TO - 1; i++) begin
            t = tick;
            step();
            if (t) ticks++;
            n_vec++; if (lose !== 1'b0) begin n_err++; $display("FAIL timeout_pre_press ticks=%0d lose=%b want=0", ticks, lose); end
        end
        for (int i = 0; i < 4 && tick !== 1'b1; i++) step();
        btn_valid = 1'b1;
        btn_code  = 2'(pat[0]);
        t = tick;
        step();
        n_vec++; if (t !== 1'b1 || lose !== 1'b0 || wait_input !== 1'b1) begin n_err++; $display("FAIL press_with_tick tick=%b lose=%b wait=%b want 1/0/1", t, lose, wait_input); end
        ticks = 0;
        for (int i = 0; i < 40 && ticks < TO; i++) begin
            t = tick;
            step();
            if (t) ticks++;
            n_vec++; if (lose !== (ticks >= TO)) begin n_err++; $display("FAIL timeout_restart ticks=%0d lose=%b want=%b", ticks, lose, ticks >= TO); end
        end
        n_vec++; if (ticks != TO) begin n_err++; $display("FAIL timeout_restart_bound got=%0d want=%0d", ticks, TO); end
        every2 = 1'b0;
    endtask

    task automatic test_random_games();
        bit done;
        int wrong_at;
        int c;
        for (int g = 0; g < 6; g++) begin
            pat.delete();
            start = 1'b1;
            step();
            done = 1'b0;
            while (!done) begin
                begin_round();
                n_vec++; if (cap_to || lvl_seen !== 4'(pat.size())) begin n_err++; $display("FAIL rand_level game=%0d got=%0d want=%0d", g, lvl_seen, pat.size()); end
                n_vec++; if (first_diff() != -1) begin n_err++; $display("FAIL rand_wave game=%0d len=%0d at=%0d", g, pat.size(), first_diff()); end
                wrong_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, pat.size() - 1)) : -1;
                foreach (pat[k]) begin
                    repeat ($urandom_range(0, 2)) step();
                    if (k == wrong_at) begin
                        do c = int'($urandom_range(0, 3)); while (c == pat[k]);
                    end else begin
                        c = pat[k];
                    end
                    btn_valid = 1'b1;
                    btn_code  = 2'(c);
                    step();
                    if (k == wrong_at) begin
                        n_vec++; if (lose !== 1'b1) begin n_err++; $display("FAIL rand_lose game=%0d got=%b want=1", g, lose); end
                        done = 1'b1;
                        break;
                    end else if (k == pat.size() - 1) begin
                        if (pat.size() == MAX_LEN) begin
                            n_vec++; if (win !== 1'b1 || level !== 4'(MAX_LEN)) begin n_err++; $display("FAIL rand_win game=%0d win=%b level=%0d", g, win, level); end
                            done = 1'b1;
                        end else begin
                            n_vec++; if ({wait_input, win, lose} !== 3'b000) begin n_err++; $display("FAIL rand_append game=%0d got=%b want=000", g, {wait_input, win, lose}); end
                        end
                    end else begin
                        n_vec++; if (wait_input !== 1'b1 || lose !== 1'b0) begin n_err++; $display("FAIL rand_mid game=%0d wait=%b lose=%b", g, wait_input, lose); end
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_first_round();
        test_growth();
        test_win_restart();
        test_wrong_press();
        test_timeout();
        test_random_games();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

endmodule
